wait_buffer_ctrl: RTL and testbench

Sequencing controller for the non-blocking data cache's wait buffer. It accepts cache misses and pushes them into the wait buffer. It issues line-fill requests to memory, merging misses to a block that already has a fill pending. When a fill returns, it drives the wait buffer through its invalidate/walk sequence, sharing the single cache-pipeline replay slot between walk replays and new core requests.

---
 rtl/wait_buffer_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_wait_buffer_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// wait_buffer_ctrl
//
// Sequencing controller for the non-blocking data cache's wait buffer.
//   * Accepts cache misses and pushes them into the wait buffer.
//   * Tracks outstanding line fills in a small circular table. A miss to a
//     block that already has a fill outstanding merges into it.
//   * Issues fill requests to memory in allocation order.
//   * When a fill returns, starts a wait-buffer walk (one invalidate/search
//     cycle, then replay cycles). The single cache-pipeline replay slot is
//     shared between walk replays and new core requests.
//
// Handshakes: every valid/ready pair transfers on a cycle where both are high.
// valid never depends on ready for the same interface. miss_ready and
// wb_write_enable are combinational in the miss inputs and in wb_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   miss_valid/addr/ready miss handshake from the cache pipeline
//   wb_write_enable       push of the accepted miss into the wait buffer
//   wb_ready              wait buffer has room
//   fill_req_*            line-fill request to memory (block-aligned address)
//   fill_resp_valid       fill completed; responses return in request order
//   wb_search_invalidate  one-cycle pulse that starts the wait-buffer walk
//   wb_search_address     block-aligned address of the returned fill
//   wb_found_multi        wait buffer still holds matching entries
//   wb_mem_ready          replay slot granted to the wait buffer
//   core_req_valid        new core request wants the pipeline
//   core_grant            core request granted the pipeline
//   busy                  fills outstanding, walk active or response queued
//   dbg_state             current FSM state (0 IDLE, 1 START, 2 WALK)
//
// Optional feature macro: WB_CTRL_FAIRNESS_EN. When defined, a core request
// that has been starved for three consecutive walk cycles takes the replay
// slot on the next such cycle.
// -----------------------------------------------------------------------------
module wait_buffer_ctrl #(
  parameter int ADDR_BITS      = 32,
  parameter int BLOCK_ID_START = 5,
  parameter int FILL_SLOTS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_valid,
  input  logic [ADDR_BITS-1:0] miss_addr,
  output logic                 miss_ready,
  output logic                 wb_write_enable,
  input  logic                 wb_ready,
  output logic                 fill_req_valid,
  output logic [ADDR_BITS-1:0] fill_req_addr,
  input  logic                 fill_req_ready,
  input  logic                 fill_resp_valid,
  output logic                 wb_search_invalidate,
  output logic [ADDR_BITS-1:0] wb_search_address,
  input  logic                 wb_found_multi,
  output logic                 wb_mem_ready,
  input  logic                 core_req_valid,
  output logic                 core_grant,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int BLK_W = ADDR_BITS - BLOCK_ID_START;
  localparam int PTR_W = $clog2(FILL_SLOTS);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef logic [BLK_W-1:0] blk_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WALK  = 2'd2
  } state_t;

  state_t state, next_state;

  // ---------------------------------------------------------------------------
  // Fill table: circular FIFO of outstanding fills
  // ---------------------------------------------------------------------------
  logic [FILL_SLOTS-1:0] ent_valid;
  logic [FILL_SLOTS-1:0] ent_pend;   // allocated but request not yet accepted
  blk_t                  ent_blk [FILL_SLOTS];
  logic [PTR_W-1:0]      head, tail;
  logic [PTR_W:0]        count;      // one extra bit so full is distinguishable

  blk_t             miss_blk;
  logic             table_full, table_empty;
  logic             resp_pop;
  logic             miss_hit;
  logic             accept, alloc;
  logic             issue_found;
  logic [PTR_W-1:0] issue_idx, scan_idx;
  logic             unused_bits;

  assign miss_blk    = miss_addr[ADDR_BITS-1:BLOCK_ID_START];
  assign unused_bits = ^miss_addr[BLOCK_ID_START-1:0];
  assign table_full  = (count == (PTR_W+1)'(FILL_SLOTS));
  assign table_empty = (count == '0);
  assign resp_pop    = fill_resp_valid & ~table_empty;

  // The head entry being retired this cycle no longer counts as a match: a
  // miss to that block needs a fresh fill, since the returning data is
  // already being walked.
  always_comb begin
    miss_hit = 1'b0;
    for (int i = 0; i < FILL_SLOTS; i++) begin
      if (ent_valid[i] && (ent_blk[i] == miss_blk) &&
          !(resp_pop && (PTR_W'(i) == head)))
        miss_hit = 1'b1;
    end
  end

  // A pop in the same cycle does not free space for a new allocation.
  assign miss_ready      = ~rst & wb_ready & (miss_hit | ~table_full);
  assign accept          = miss_valid & miss_ready;
  assign alloc           = accept & ~miss_hit;
  assign wb_write_enable = accept;

  // Oldest allocated-but-unissued entry, scanning from head.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = head;
    scan_idx    = head;
    for (int i = 0; i < FILL_SLOTS; i++) begin
      scan_idx = head + PTR_W'(i);
      if (!issue_found && ent_valid[scan_idx] && ent_pend[scan_idx]) begin
        issue_found = 1'b1;
        issue_idx   = scan_idx;
      end
    end
  end

  assign fill_req_valid = issue_found;
  assign fill_req_addr  = issue_found ? {ent_blk[issue_idx], {BLOCK_ID_START{1'b0}}}
                                      : '0;

  // alloc writes tail, pop writes head; they only coincide when the table is
  // full (no alloc) or empty (no pop), so the writes never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_pend  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (fill_req_valid && fill_req_ready)
        ent_pend[issue_idx] <= 1'b0;
      if (alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_pend[tail]  <= 1'b1;
        ent_blk[tail]   <= miss_blk;
        tail            <= tail + PTR_ONE;
      end
      if (resp_pop) begin
        ent_valid[head] <= 1'b0;
        ent_pend[head]  <= 1'b0;
        head            <= head + PTR_ONE;
      end
      count <= count + (PTR_W+1)'(alloc) - (PTR_W+1)'(resp_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO (2 deep). The front entry is the block being started; it
  // leaves the FIFO as the FSM moves from START to WALK.
  // ---------------------------------------------------------------------------
  blk_t       rq_blk [2];
  logic       rq_wptr, rq_rptr;
  logic [1:0] rq_count;
  logic       rq_push, rq_pop;
  logic       resp_pending;

  assign rq_pop       = (state == START);
  assign rq_push      = resp_pop & ((rq_count != 2'd2) | rq_pop);
  assign resp_pending = (rq_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_wptr  <= 1'b0;
      rq_rptr  <= 1'b0;
      rq_count <= '0;
    end else begin
      if (rq_push) begin
        rq_blk[rq_wptr] <= ent_blk[head];
        rq_wptr         <= ~rq_wptr;
      end
      if (rq_pop)
        rq_rptr <= ~rq_rptr;
      rq_count <= rq_count + 2'(rq_push) - 2'(rq_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Walk FSM
  // ---------------------------------------------------------------------------
  logic fair_grant;

`ifdef WB_CTRL_FAIRNESS_EN
  // Counts consecutive walk cycles where the core asked but the replay won.
  logic [1:0] fair_cnt;

  assign fair_grant = (state == WALK) && core_req_valid && (fair_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || (state != WALK) || (next_state != WALK) || fair_grant ||
        !core_req_valid)
      fair_cnt <= 2'd0;
    else
      fair_cnt <= fair_cnt + 2'd1;
  end
`else
  assign fair_grant = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (resp_pending) next_state = START;
      START:   next_state = WALK;
      WALK:    if (wb_mem_ready && !wb_found_multi) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wb_search_invalidate = 1'b0;
    wb_search_address    = '0;
    wb_mem_ready         = 1'b0;
    core_grant           = 1'b0;
    case (state)
      IDLE: core_grant = core_req_valid & ~resp_pending;
      START: begin
        wb_search_invalidate = 1'b1;
        wb_search_address    = {rq_blk[rq_rptr], {BLOCK_ID_START{1'b0}}};
        core_grant           = core_req_valid;
      end
      WALK: begin
        wb_mem_ready = ~fair_grant;
        core_grant   = fair_grant;
      end
      default: ;
    endcase
  end

  assign busy      = (|ent_valid) | (state != IDLE) | resp_pending;
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Protocol assertions
  // ---------------------------------------------------------------------------
  a_resp_on_empty: assert property (@(posedge clk) disable iff (rst)
    !(fill_resp_valid && table_empty));
  a_resp_overflow: assert property (@(posedge clk) disable iff (rst)
    !(resp_pop && (rq_count == 2'd2) && !rq_pop));

endmodule

// File: tb/tb_wait_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for wait_buffer_ctrl. Directed scenarios followed by a randomized
// run checked against a queue-based reference model of the controller.
// -----------------------------------------------------------------------------
module tb_wait_buffer_ctrl;

  localparam int ADDR_BITS  = 32;
  localparam int FILL_SLOTS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 miss_valid;
  logic [ADDR_BITS-1:0] miss_addr;
  logic                 miss_ready;
  logic                 wb_write_enable;
  logic                 wb_ready;
  logic                 fill_req_valid;
  logic [ADDR_BITS-1:0] fill_req_addr;
  logic                 fill_req_ready;
  logic                 fill_resp_valid;
  logic                 wb_search_invalidate;
  logic [ADDR_BITS-1:0] wb_search_address;
  logic                 wb_found_multi;
  logic                 wb_mem_ready;
  logic                 core_req_valid;
  logic                 core_grant;
  logic                 busy;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  wait_buffer_ctrl #(.ADDR_BITS(ADDR_BITS), .BLOCK_ID_START(5), .FILL_SLOTS(FILL_SLOTS)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .wb_write_enable(wb_write_enable), .wb_ready(wb_ready),
    .fill_req_valid(fill_req_valid), .fill_req_addr(fill_req_addr),
    .fill_req_ready(fill_req_ready), .fill_resp_valid(fill_resp_valid),
    .wb_search_invalidate(wb_search_invalidate), .wb_search_address(wb_search_address),
    .wb_found_multi(wb_found_multi), .wb_mem_ready(wb_mem_ready),
    .core_req_valid(core_req_valid), .core_grant(core_grant),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; wb_ready = 1'b0;
    fill_req_ready = 1'b0; fill_resp_valid = 1'b0; wb_found_multi = 1'b0;
    core_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver helpers ----------------
  task automatic wait_for_start(input string name);
    int waited;
    waited = 0;
    while (wb_search_invalidate !== 1'b1 && waited < 4) begin
      @(negedge clk); #1; waited++;
    end
    n_checks++; if (wb_search_invalidate !== 1'b1) begin n_fail++; $display("FAIL %s_start_timeout got=%0b exp=1", name, wb_search_invalidate); end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (miss_ready !== 1'b0) begin n_fail++; $display("FAIL reset_miss_ready got=%0b exp=0", miss_ready); end
    n_checks++; if (wb_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_wb_we got=%0b exp=0", wb_write_enable); end
    n_checks++; if (fill_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fill_req_valid got=%0b exp=0", fill_req_valid); end
    n_checks++; if (wb_search_invalidate !== 1'b0) begin n_fail++; $display("FAIL reset_invalidate got=%0b exp=0", wb_search_invalidate); end
    n_checks++; if (wb_mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got=%0b exp=0", wb_mem_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_checks++; if (core_grant !== 1'b0) begin n_fail++; $display("FAIL reset_core_grant0 got=%0b exp=0", core_grant); end
    core_req_valid = 1'b1; #1;
    n_checks++; if (core_grant !== 1'b1) begin n_fail++; $display("FAIL reset_core_grant1 got=%0b exp=1", core_grant); end
    core_req_valid = 1'b0;
  endtask

  task automatic test_miss_issue();
    do_reset();
    wb_ready = 1'b1; fill_req_ready = 1'b1;
    miss_valid = 1'b1; miss_addr = 32'h0000_1004; #1;
    n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL issue_miss_ready got=%0b exp=1", miss_ready); end
    n_checks++; if (wb_write_enable !== 1'b1) begin n_fail++; $display("FAIL issue_wb_we got=%0b exp=1", wb_write_enable); end
    n_checks++; if (fill_req_valid !== 1'b0) begin n_fail++; $display("FAIL issue_early_req got=%0b exp=0", fill_req_valid); end
    @(negedge clk); miss_valid = 1'b0; #1;
    n_checks++; if (fill_req_valid !== 1'b1) begin n_fail++; $display("FAIL issue_req_valid got=%0b exp=1", fill_req_valid); end
    n_checks++; if (fill_req_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL issue_req_addr got=%h exp=00001000", fill_req_addr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL issue_busy got=%0b exp=1", busy); end
    @(negedge clk);
  endtask

  // Runs right after test_miss_issue: the 0x1000 fill is issued and pending.
  task automatic test_merge();
    miss_valid = 1'b1; miss_addr = 32'h0000_101C; #1;
    n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL merge_miss_ready got=%0b exp=1", miss_ready); end
    n_checks++; if (wb_write_enable !== 1'b1) begin n_fail++; $display("FAIL merge_wb_we got=%0b exp=1", wb_write_enable); end
    fill_req_ready = 1'b0;
    @(negedge clk); miss_addr = 32'h0000_2000; #1;
    n_checks++; if (fill_req_valid !== 1'b0) begin n_fail++; $display("FAIL merge_no_new_req got=%0b exp=0", fill_req_valid); end
    // With one entry in use, exactly three more distinct blocks fit.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); miss_addr = 32'((i + 2) << 12); #1; end
      n_checks++; if (miss_ready !== (i < 3)) begin n_fail++; $display("FAIL merge_capacity_%0d got=%0b exp=%0b", i, miss_ready, (i < 3)); end
    end
    @(negedge clk); miss_valid = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    wb_ready = 1'b1; fill_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1; miss_addr = 32'(((i + 2) << 12) | 4); #1;
      n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_%0d got=%0b exp=1", i, miss_ready); end
      @(negedge clk);
    end
    miss_addr = 32'h0000_6008;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (miss_ready !== 1'b0 || wb_write_enable !== 1'b0) begin n_fail++; $display("FAIL full_blocked_%0d got=%0b/%0b exp=0/0", i, miss_ready, wb_write_enable); end
      @(negedge clk);
    end
    miss_addr = 32'h0000_3010; #1;
    n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL full_merge got=%0b exp=1", miss_ready); end
    @(negedge clk);
    // Pop of the head in the same cycle does not free space.
    miss_addr = 32'h0000_2004; fill_resp_valid = 1'b1; #1;
    n_checks++; if (miss_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle got=%0b exp=0", miss_ready); end
    @(negedge clk); fill_resp_valid = 1'b0; miss_addr = 32'h0000_6008; #1;
    n_checks++; if (miss_ready !== 1'b1 || wb_write_enable !== 1'b1) begin n_fail++; $display("FAIL full_after_pop got=%0b/%0b exp=1/1", miss_ready, wb_write_enable); end
    @(negedge clk); miss_valid = 1'b0; #1;
    n_checks++; if (fill_req_valid !== 1'b1 || fill_req_addr !== 32'h0000_6000) begin n_fail++; $display("FAIL full_new_req got=%0b/%h exp=1/00006000", fill_req_valid, fill_req_addr); end
    @(negedge clk);
  endtask

  task automatic test_walk();
    do_reset();
    wb_ready = 1'b1; fill_req_ready = 1'b1;
    miss_valid = 1'b1; miss_addr = 32'h0000_1004;
    @(negedge clk); miss_valid = 1'b0;
    @(negedge clk); fill_req_ready = 1'b0;
    // Miss to the block returning this cycle needs a fresh fill.
    fill_resp_valid = 1'b1; miss_valid = 1'b1; miss_addr = 32'h0000_1008; #1;
    n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL walk_miss_on_pop got=%0b exp=1", miss_ready); end
    @(negedge clk); fill_resp_valid = 1'b0; miss_valid = 1'b0; #1;
    n_checks++; if (fill_req_valid !== 1'b1 || fill_req_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL walk_refill_req got=%0b/%h exp=1/00001000", fill_req_valid, fill_req_addr); end
    wait_for_start("walk");
    n_checks++; if (wb_search_address !== 32'h0000_1000) begin n_fail++; $display("FAIL walk_search_addr got=%h exp=00001000", wb_search_address); end
    n_checks++; if (wb_mem_ready !== 1'b0) begin n_fail++; $display("FAIL walk_start_mem_ready got=%0b exp=0", wb_mem_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); wb_found_multi = (k < 2); #1;
      n_checks++; if (wb_mem_ready !== 1'b1 || wb_search_invalidate !== 1'b0) begin n_fail++; $display("FAIL walk_replay_%0d got=%0b/%0b exp=1/0", k, wb_mem_ready, wb_search_invalidate); end
    end
    @(negedge clk); wb_found_multi = 1'b0; #1;
    n_checks++; if (wb_mem_ready !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL walk_end got=%0b/%0d exp=0/0", wb_mem_ready, dbg_state); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic exp_core;
    do_reset();
    wb_ready = 1'b1; fill_req_ready = 1'b1;
    miss_valid = 1'b1; miss_addr = 32'h0000_1004;
    @(negedge clk); miss_valid = 1'b0;
    @(negedge clk); fill_resp_valid = 1'b1;
    @(negedge clk); fill_resp_valid = 1'b0; core_req_valid = 1'b1; #1;
    wait_for_start("fair");
    n_checks++; if (core_grant !== 1'b1) begin n_fail++; $display("FAIL fair_start_grant got=%0b exp=1", core_grant); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); wb_found_multi = 1'b1; #1;
`ifdef WB_CTRL_FAIRNESS_EN
      exp_core = (c == 4) || (c == 8);
`else
      exp_core = 1'b0;
`endif
      n_checks++; if (core_grant !== exp_core || wb_mem_ready !== !exp_core) begin n_fail++; $display("FAIL fair_walk_cycle_%0d got=%0b/%0b exp=%0b/%0b", c, core_grant, wb_mem_ready, exp_core, !exp_core); end
    end
    @(negedge clk); wb_found_multi = 1'b0; #1;
    n_checks++; if (wb_mem_ready !== 1'b1) begin n_fail++; $display("FAIL fair_exit_replay got=%0b exp=1", wb_mem_ready); end
    @(negedge clk); #1;
    n_checks++; if (core_grant !== 1'b1 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL fair_idle_grant got=%0b/%0d exp=1/0", core_grant, dbg_state); end
    core_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    wb_ready = 1'b1; fill_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1; miss_addr = 32'((i + 1) << 12);
      @(negedge clk);
    end
    miss_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    fill_resp_valid = 1'b1;
    @(negedge clk); fill_resp_valid = 1'b0; #1;
    wait_for_start("rstwalk");
    @(negedge clk); wb_found_multi = 1'b1; #1;
    n_checks++; if (dbg_state !== 2'd2 || wb_mem_ready !== 1'b1) begin n_fail++; $display("FAIL rstwalk_in_walk got=%0d/%0b exp=2/1", dbg_state, wb_mem_ready); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rstwalk_state got=%0d exp=0", dbg_state); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwalk_busy got=%0b exp=0", busy); end
    n_checks++; if (fill_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstwalk_req got=%0b exp=0", fill_req_valid); end
    n_checks++; if (wb_mem_ready !== 1'b0) begin n_fail++; $display("FAIL rstwalk_mem_ready got=%0b exp=0", wb_mem_ready); end
    wb_found_multi = 1'b0;
  endtask

  // ---------------- randomized run against reference model ----------------
  typedef struct packed {
    logic [26:0] blk;
    logic        issued;
  } fill_t;

  task automatic test_random();
    fill_t       fq[$];        // outstanding fills, oldest first
    logic [26:0] rq[$];        // returned blocks not yet past their start cycle
    logic [26:0] pool [6];
    logic [26:0] mb, popped;
    int          phase;        // 0 idle, 1 start, 2 walk
    int          next_phase;
    int          fair_cnt;
    int          issue_i;
    logic        match, fair, exp_mr, exp_we, exp_mem, exp_core, exp_busy;
    logic        accept;
    phase = 0; fair_cnt = 0;
    for (int i = 0; i < 6; i++) pool[i] = 27'(32'h80 + i * 3);
    do_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      miss_valid      = ($urandom_range(0, 99) < 50);
      mb              = pool[$urandom_range(0, 5)];
      miss_addr       = {mb, 5'($urandom_range(0, 31))};
      wb_ready        = ($urandom_range(0, 9) != 0);
      fill_req_ready  = ($urandom_range(0, 1) == 1);
      fill_resp_valid = (fq.size() > 0) && fq[0].issued && (rq.size() < 2) &&
                        ($urandom_range(0, 3) == 0);
      wb_found_multi  = ($urandom_range(0, 2) != 0);
      core_req_valid  = ($urandom_range(0, 1) == 1);
      #1;
      // expected outputs from the model's view of the rules
      match = 1'b0;
      foreach (fq[i]) if (fq[i].blk == mb && !(fill_resp_valid && i == 0)) match = 1'b1;
      issue_i = -1;
      foreach (fq[i]) if (issue_i < 0 && !fq[i].issued) issue_i = i;
`ifdef WB_CTRL_FAIRNESS_EN
      fair = (phase == 2) && core_req_valid && (fair_cnt == 3);
`else
      fair = 1'b0;
`endif
      exp_mr   = wb_ready && (match || fq.size() < FILL_SLOTS);
      exp_we   = miss_valid && exp_mr;
      exp_mem  = (phase == 2) && !fair;
      exp_core = (phase == 0) ? (core_req_valid && rq.size() == 0) :
                 (phase == 1) ? core_req_valid : fair;
      exp_busy = (fq.size() != 0) || (phase != 0) || (rq.size() != 0);
      n_checks++; if (miss_ready !== exp_mr) begin n_fail++; $display("FAIL rnd_miss_ready cyc=%0d got=%0b exp=%0b", cyc, miss_ready, exp_mr); end
      n_checks++; if (wb_write_enable !== exp_we) begin n_fail++; $display("FAIL rnd_wb_we cyc=%0d got=%0b exp=%0b", cyc, wb_write_enable, exp_we); end
      n_checks++; if (fill_req_valid !== (issue_i >= 0)) begin n_fail++; $display("FAIL rnd_req_valid cyc=%0d got=%0b exp=%0b", cyc, fill_req_valid, (issue_i >= 0)); end
      if (issue_i >= 0) begin
        n_checks++; if (fill_req_addr !== {fq[issue_i].blk, 5'b0}) begin n_fail++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, fill_req_addr, {fq[issue_i].blk, 5'b0}); end
      end
      n_checks++; if (wb_search_invalidate !== (phase == 1)) begin n_fail++; $display("FAIL rnd_invalidate cyc=%0d got=%0b exp=%0b", cyc, wb_search_invalidate, (phase == 1)); end
      if (phase == 1) begin
        n_checks++; if (wb_search_address !== {rq[0], 5'b0}) begin n_fail++; $display("FAIL rnd_search_addr cyc=%0d got=%h exp=%h", cyc, wb_search_address, {rq[0], 5'b0}); end
      end
      n_checks++; if (wb_mem_ready !== exp_mem) begin n_fail++; $display("FAIL rnd_mem_ready cyc=%0d got=%0b exp=%0b", cyc, wb_mem_ready, exp_mem); end
      n_checks++; if (core_grant !== exp_core) begin n_fail++; $display("FAIL rnd_core_grant cyc=%0d got=%0b exp=%0b", cyc, core_grant, exp_core); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_busy); end
      // advance the model to the next cycle
      accept = exp_we;
      if (fill_req_ready && issue_i >= 0) fq[issue_i].issued = 1'b1;
      if (accept && !match) fq.push_back('{blk: mb, issued: 1'b0});
      popped = '0;
      if (fill_resp_valid) begin popped = fq[0].blk; fq.pop_front(); end
      next_phase = phase;
      if (phase == 0 && rq.size() > 0) next_phase = 1;
      else if (phase == 1) begin next_phase = 2; rq.pop_front(); end
      else if (phase == 2 && exp_mem && !wb_found_multi) next_phase = 0;
      if (phase == 2 && next_phase == 2 && !fair && core_req_valid) fair_cnt++;
      else fair_cnt = 0;
      phase = next_phase;
      if (fill_resp_valid) rq.push_back(popped);
      @(negedge clk);
    end
    miss_valid = 1'b0; fill_resp_valid = 1'b0; core_req_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_miss_issue();
    test_merge();
    test_full();
    test_walk();
    test_fairness();
    test_reset_mid_walk();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
